// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract unsigned divider, one quotient bit per clock
module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff
);
    assign diff = a - b;
endmodule

module seq_divider #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);
    localparam int CW = $clog2(SIZE + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] div_q, div_d;
    logic            zero_q, zero_d;
    logic [SIZE-1:0] quotient_q, quotient_d;
    logic [SIZE-1:0] remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic [SIZE:0]   shifted, trial;
    logic            accept;

    assign shifted = {rem_q, quo_q[SIZE-1]};

    subtractor #(.WIDTH(SIZE + 1)) u_sub (
        .a    (shifted),
        .b    ({1'b0, div_q}),
        .diff (trial)
    );

    // zero_q marks the single wait cycle of a divide-by-zero request before DONE
    assign accept = start && ((state_q == IDLE && !zero_q) || state_q == DONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (state_q == RUN) begin
            rem_d = trial[SIZE] ? shifted[SIZE-1:0] : trial[SIZE-1:0];
            quo_d = {quo_q[SIZE-2:0], ~trial[SIZE]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d     = DONE;
                quotient_d  = quo_d;
                remainder_d = rem_d;
                dbz_d       = 1'b0;
            end
        end else if (zero_q) begin
            state_d     = DONE;
            zero_d      = 1'b0;
            quotient_d  = '1;
            remainder_d = quo_q;
            dbz_d       = 1'b1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        if (accept) begin
            div_d   = divisor;
            quo_d   = dividend;
            rem_d   = '0;
            cnt_d   = CW'(SIZE);
            zero_d  = (divisor == '0);
            state_d = (divisor == '0) ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against plain / and % arithmetic
module tb_seq_divider;
    logic        clk, rst, start, busy, done, div_by_zero;
    logic [31:0] dividend, divisor, quotient, remainder;
    int          errors = 0;
    int          checks = 0;

    seq_divider #(.SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n counts negedges after the accepting edge until done is seen (1 = right after that edge)
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 100);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n, nb;
        launch(a, b);
        wait_done(n, nb);
        check({tag, "_lat"}, 64'(n), (b == 0) ? 64'd2 : 64'd33);
        check({tag, "_busy"}, 64'(nb), (b == 0) ? 64'd0 : 64'd32);
        check({tag, "_q"}, 64'(quotient), (b == 0) ? 64'hFFFF_FFFF : 64'(a / b));
        check({tag, "_r"}, 64'(remainder), (b == 0) ? 64'(a) : 64'(a % b));
        check({tag, "_dbz"}, 64'(div_by_zero), (b == 0) ? 64'd1 : 64'd0);
        @(negedge clk);
        check({tag, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, nb, seen;
        logic [31:0] a, b;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        run_check("d100_7", 32'd100, 32'd7);
        run_check("dmax_1", 32'hFFFF_FFFF, 32'd1);
        run_check("d5_9", 32'd5, 32'd9);
        run_check("dz1234", 32'd1234, 32'd0);
        run_check("after_dz", 32'd100, 32'd7);
        run_check("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // back-to-back: start held high, operands changed during RUN must be ignored
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1 dividend = 32'd50;
        divisor = 32'd3;
        wait_done(n, nb);
        check("b2b1_lat", 64'(n), 64'd33);
        check("b2b1_q", 64'(quotient), 64'd14);
        check("b2b1_r", 64'(remainder), 64'd2);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_hold_q", 64'(quotient), 64'd14);
        check("b2b_hold_busy", 64'(busy), 64'd1);
        wait_done(n, nb);
        check("b2b2_lat", 64'(n), 64'd23);
        check("b2b2_q", 64'(quotient), 64'd16);
        check("b2b2_r", 64'(remainder), 64'd2);

        // reset in the middle of a run
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_q", 64'(quotient), 64'd0);
        check("mid_rst_r", 64'(remainder), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("mid_rst_no_done", 64'(seen), 64'd0);
        run_check("post_rst", 32'd50, 32'd3);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (b == 0) b = 32'd1;
            launch(a, b);
            wait_done(n, nb);
            check("rnd_lat", 64'(n), 64'd33);
            check("rnd_q", 64'(quotient), 64'(a / b));
            check("rnd_r", 64'(remainder), 64'(a % b));
            check("rnd_recon", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            check("rnd_rlt", 64'(remainder < b), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, operation request, sampled on a rising edge.
REQ-005 SHALL have port dividend, input, SIZE, unsigned numerator, sampled with an accepted start.
REQ-006 SHALL have port divisor, input, SIZE, unsigned denominator, sampled with an accepted start.
REQ-007 SHALL have port busy, output, 1, high while an iteration sequence is running.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a result is published.
REQ-009 SHALL have port quotient, output, SIZE, registered result.
REQ-010 SHALL have port remainder, output, SIZE, registered result.
REQ-011 SHALL have port div_by_zero, output, 1, registered flag for the last published result.

Function
REQ-012 SHALL implement a restoring shift-subtract divider with states IDLE, RUN and DONE.
REQ-013 SHALL perform every trial subtraction through exactly one instance of the team subtractor module, with SIZE+1 as that instance's width; no other subtraction logic is permitted.
REQ-014 SHALL accept start only in IDLE or DONE; start while in RUN SHALL be ignored, with no effect on state or operands.
REQ-015 On an accepted start with divisor != 0, SHALL latch the operands, clear the partial remainder (SIZE+1 bits), load the quotient shift register with dividend, load the iteration counter with SIZE, and enter RUN.
REQ-016 Each RUN cycle SHALL shift {partial remainder, quotient register} left by 1, form trial = shifted remainder - {0,divisor}, and apply the result: if trial MSB = 0, remainder <= trial and quotient LSB <= 1; otherwise remainder is kept and LSB <= 0.
REQ-017 SHALL decrement the counter once per RUN cycle, and SHALL move to DONE on the edge that completes the SIZE-th iteration.
REQ-018 On entry to DONE, SHALL copy the final quotient to quotient and the remainder's low SIZE bits to remainder, and SHALL clear div_by_zero.
REQ-019 Latency: for start accepted at edge k, done SHALL be sampled high at edge k+SIZE+1 and low at edge k+SIZE+2 (unless a new start is accepted there).
REQ-020 DONE SHALL last exactly one cycle; the next state is IDLE, or RUN if start is asserted in DONE (back-to-back operation).
REQ-021 On an accepted start with divisor = 0, SHALL skip RUN, enter DONE on the next edge (done sampled high at edge k+2), publish quotient = all ones and remainder = dividend, and set div_by_zero = 1.
REQ-022 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both SHALL be driven from registered state only.
REQ-023 quotient, remainder and div_by_zero SHALL change only on entry to DONE, and SHALL hold their values in IDLE and throughout any following RUN.
REQ-024 Operand inputs SHALL be don't-care except on an accepted start edge.

Reset
REQ-025 While rst is high at a rising edge, SHALL set state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, and clear all internal registers.
REQ-026 rst SHALL take priority over start; a reset during RUN SHALL abort the operation, and no done pulse SHALL follow for it.

Verification
REQ-027 SIZE=32, dividend=100, divisor=7, start at edge k -> busy high at edges k+1..k+32, done high at edge k+33 only, quotient=14, remainder=2, div_by_zero=0.
REQ-028 SIZE=32, dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-029 SIZE=32, dividend=1234, divisor=0 -> done at edge k+2, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1; the next valid division SHALL clear div_by_zero.
REQ-030 Start 100/7 held high with operands changed to 50/3 during RUN -> result 14 r 2; start still high in DONE launches 50/3 back-to-back -> 16 r 2, done at edge k+33+33.
REQ-031 rst asserted at edge k+10 of a run -> all outputs 0 at edge k+11, no done pulse, and a fresh start afterwards completes correctly.
REQ-032 Random self-check: 1000 random operand pairs (SIZE=32, divisor nonzero) -> quotient*divisor+remainder = dividend and remainder < divisor for every result.
